mdu_ctrl: RTL and testbench

- Sequencing controller for the HI/LO multiply-divide resource in the P7 five-stage MIPS pipeline.
- Accepts md operations from the E stage and runs multi-cycle MULT/DIV with a latency counter.
- Commits results to the HI/LO registers; these values feed the E/M pipeline register's hi/lo fields.
- Drives a stall request that freezes F/D while a younger md instruction waits, and honours exception flush (req).

---
 rtl/mdu_ctrl_pkg.sv | 46 ++++
 rtl/mdu_ctrl_arith.sv | 62 ++++++
 rtl/mdu_ctrl.sv | 114 +++++++++++
 tb/tb_mdu_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared md_op codes, FSM state codes and op-class helpers for the HI/LO unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // Ops that occupy the multiplier for MULT_CYCLES
    function automatic logic op_is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
               (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_valid(input logic [3:0] op);
        return op_is_mul(op) || op_is_div(op) ||
               (op == MD_MTHI) || (op == MD_MTLO) || (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational 64-bit product and quotient/remainder from the captured operands,
// including the divide-by-zero and signed-overflow results.
module mdu_ctrl_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic               mul_signed;
    logic               div_signed;
    logic               div_zero;
    logic               div_ovf;
    logic [63:0]        ext_a;
    logic [63:0]        ext_b;
    logic signed [31:0] s_a;
    logic signed [31:0] s_b;
    logic signed [31:0] s_q;
    logic signed [31:0] s_r;
    logic [31:0]        u_b;
    logic [31:0]        u_q;
    logic [31:0]        u_r;

`ifdef MDU_MADD_EN
    assign mul_signed = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
`else
    assign mul_signed = (op == MD_MULT);
`endif
    assign div_signed = (op == MD_DIV);
    assign div_zero   = (b == 32'd0);
    assign div_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Low 64 bits of the extended product are exact for both signednesses
    assign ext_a = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign ext_b = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign prod  = ext_a * ext_b;

    always_comb begin
        // Divisor forced to 1 on the special cases so the real dividers never see them
        s_a = $signed(a);
        s_b = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
        s_q = s_a / s_b;
        s_r = s_a % s_b;
        u_b = div_zero ? 32'd1 : b;
        u_q = a / u_b;
        u_r = a % u_b;
        quo = div_signed ? s_q : u_q;
        rem = div_signed ? s_r : u_r;
        if (div_zero) begin
            quo = 32'hFFFF_FFFF;
            rem = a;
        end else if (div_signed && div_ovf) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide sequencer: op accept, latency counter, HI/LO commit, F/D stall.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops on the MUL path.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e     state;
    mdu_state_e     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]     cap_op;
    logic [31:0]    cap_a;
    logic [31:0]    cap_b;
    logic           accept;
    logic           commit;
    logic [63:0]    prod;
    logic [31:0]    quo;
    logic [31:0]    rem;
    logic [63:0]    res;

    assign accept = start && !req && (state == ST_IDLE) && op_is_valid(op);
    assign busy   = (state != ST_IDLE);
    assign stall  = d_md_use && (busy || (start && !req && (op_is_mul(op) || op_is_div(op))));

    mdu_ctrl_arith u_arith (
        .op   (cap_op),
        .a    (cap_a),
        .b    (cap_b),
        .prod (prod),
        .quo  (quo),
        .rem  (rem)
    );

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && op_is_mul(op)) state_nxt = ST_MUL;
                else if (accept && op_is_div(op)) state_nxt = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Accumulate ops read HI/LO as they stand at the commit edge
    always_comb begin
        res = {hi, lo};
        case (cap_op)
            MD_MULT, MD_MULTU: res = prod;
            MD_DIV, MD_DIVU:   res = {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: res = {hi, lo} + prod;
            MD_MSUB, MD_MSUBU: res = {hi, lo} - prod;
`endif
            default:           res = {hi, lo};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cap_op <= 4'd0;
            cap_a  <= 32'd0;
            cap_b  <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept && (op_is_mul(op) || op_is_div(op))) begin
                cap_op <= op;
                cap_a  <= rs;
                cap_b  <= rt;
                cnt    <= op_is_mul(op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            end else if (busy && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end else if (accept && op == MD_MTHI) begin
                hi <= rs;
            end else if (accept && op == MD_MTLO) begin
                lo <= rs;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default build, MDU_MADD_EN undefined).
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one long op, count busy cycles, optionally pulse req+start mid-op, check results
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic use_d, input int req_at);
        int n;
        start = 1'b1; op = o; rs = a; rt = b; d_md_use = use_d;
        #1;
        check({tag, "_stall_accept"}, 32'(stall), 32'(use_d));
        tick();
        start = 1'b0; rs = 32'h1234_5678; rt = 32'h0000_0000;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            if (use_d) check({tag, "_stall_busy"}, 32'(stall), 32'd1);
            if (n == req_at) begin
                req = 1'b1; start = 1'b1; op = 4'd5;
            end
            n++;
            tick();
            req = 1'b0; start = 1'b0; op = 4'd0;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        d_md_use = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; start = 1'b0; op = 4'd0;
        rs = 32'd0; rt = 32'd0; d_md_use = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, -1);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, -1);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
        run_op("div_negdiv", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, -1);
        run_op("divu_big", 4'd4, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, -1);
        run_op("divu_zero", 4'd4, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0, -1);

        // Flush in the same cycle as start drops the op
        start = 1'b1; req = 1'b1; op = 4'd1; rs = 32'd5; rt = 32'd5;
        tick();
        start = 1'b0; req = 1'b0;
        check("req_drop_busy", 32'(busy), 32'd0);
        tick();
        check("req_drop_busy2", 32'(busy), 32'd0);
        check("req_drop_hi", hi, 32'h0000_0000);
        check("req_drop_lo", lo, 32'h8000_0000);

        // req (plus a stray start) at the third busy cycle is ignored
        run_op("div_req", 4'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, 2);
        // MFLO waiting in D: stall through every busy cycle
        run_op("mult_stall", 4'd1, 32'd7, 32'd6, 5, 32'd0, 32'd42, 1'b1, -1);

        start = 1'b1; op = 4'd5; rs = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_lo", lo, 32'd42);
        check("mthi_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 4'd6; rs = 32'hCAFE_F00D;
        tick();
        start = 1'b0;
        check("mtlo_lo", lo, 32'hCAFE_F00D);
        check("mtlo_hi", hi, 32'hDEAD_BEEF);

        // MFHI and undefined encodings leave everything alone
        start = 1'b1; op = 4'd7; rs = 32'h1111_1111;
        tick();
        op = 4'd9; rs = 32'h2222_2222; rt = 32'd3;
        tick();
        op = 4'd13;
        tick();
        start = 1'b0;
        check("noop_busy", 32'(busy), 32'd0);
        check("noop_hi", hi, 32'hDEAD_BEEF);
        check("noop_lo", lo, 32'hCAFE_F00D);

        // Reset mid-DIV discards the op
        start = 1'b1; op = 4'd3; rs = 32'd100; rt = 32'd7;
        tick();
        start = 1'b0;
        tick(); tick();
        check("middiv_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("middiv_rst_busy", 32'(busy), 32'd0);
        check("middiv_rst_hi", hi, 32'd0);
        check("middiv_rst_lo", lo, 32'd0);
        tick();
        check("middiv_rst_busy2", 32'(busy), 32'd0);
        run_op("post_rst_mult", 4'd1, 32'd5, 32'd5, 5, 32'd0, 32'd25, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
